// File: rtl/frame_filler_if.sv
// Command and SRAM write-port bundle for frame_filler.
// The master side issues fill commands and receives SRAM writes; the slave side is the filler.
interface frame_filler_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [9:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [9:0]  cmd_h;
    logic [31:0] cmd_color;
    logic        sram_wr_en;
    logic [18:0] sram_wr_addr;
    logic [31:0] sram_wr_data;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, sram_wr_en, sram_wr_addr, sram_wr_data
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, sram_wr_en, sram_wr_addr, sram_wr_data
    );
endinterface

// File: rtl/frame_filler.sv
// Rectangle fill engine writing one pixel word per cycle into the back page,
// with a vsync-aligned front/back page flip on request.
module frame_filler #(
    parameter int unsigned H_RES = 800,
    parameter int unsigned V_RES = 600
) (
    input  logic          clk,
    input  logic          rst_n,
    frame_filler_if.slave bus,
    input  logic          swap_req,
    input  logic          vga_vsync,
    output logic          wr_addr_offset,
    output logic          rd_addr_offset,
    output logic          busy,
    output logic          swap_done
);
    typedef enum logic [1:0] {IDLE, FILL, SWAP_WAIT} state_e;

    localparam logic [10:0] H_END  = 11'(H_RES);
    localparam logic [10:0] V_END  = 11'(V_RES);
    localparam logic [18:0] H_STEP = 19'(H_RES);

    state_e      state_q, state_d;
    logic [9:0]  col_start_q, col_start_d;
    logic [9:0]  col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic [10:0] col_end_q, col_end_d;
    logic [10:0] row_end_q, row_end_d;
    logic [18:0] row_base_q, row_base_d;
    logic [31:0] color_q, color_d;
    logic        pend_q, pend_d;
    logic        rd_off_q, rd_off_d;
    logic        swap_done_q, swap_done_d;
    logic        vs_meta_q, vs_sync_q, vs_prev_q;

    logic        accept;
    logic        degenerate;
    logic        vs_rise;
    logic        flip;
    logic        last_col;
    logic        last_row;
    logic [10:0] x_plus_w;
    logic [10:0] y_plus_h;

    assign x_plus_w   = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w};
    assign y_plus_h   = {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h};
    assign degenerate = (bus.cmd_w == '0) || (bus.cmd_h == '0) ||
                        ({1'b0, bus.cmd_x} >= H_END) || ({1'b0, bus.cmd_y} >= V_END);
    assign accept     = bus.cmd_valid && bus.cmd_ready;
    assign vs_rise    = vs_sync_q && !vs_prev_q;
    assign flip       = (state_q == SWAP_WAIT) && vs_rise;
    assign last_col   = ({1'b0, col_q} + 11'd1) == col_end_q;
    assign last_row   = ({1'b0, row_q} + 11'd1) == row_end_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_start_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
            col_end_q   <= '0;
            row_end_q   <= '0;
            row_base_q  <= '0;
            color_q     <= '0;
            pend_q      <= 1'b0;
            rd_off_q    <= 1'b0;
            swap_done_q <= 1'b0;
            vs_meta_q   <= 1'b0;
            vs_sync_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_start_q <= col_start_d;
            col_q       <= col_d;
            row_q       <= row_d;
            col_end_q   <= col_end_d;
            row_end_q   <= row_end_d;
            row_base_q  <= row_base_d;
            color_q     <= color_d;
            pend_q      <= pend_d;
            rd_off_q    <= rd_off_d;
            swap_done_q <= swap_done_d;
            vs_meta_q   <= vga_vsync;
            vs_sync_q   <= vs_meta_q;
            vs_prev_q   <= vs_sync_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pend_q || swap_req) begin
                    state_d = SWAP_WAIT;
                end else if (accept && !degenerate) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (last_col && last_row) begin
                    state_d = IDLE;
                end
            end
            SWAP_WAIT: begin
                if (vs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_start_d = col_start_q;
        col_d       = col_q;
        row_d       = row_q;
        col_end_d   = col_end_q;
        row_end_d   = row_end_q;
        row_base_d  = row_base_q;
        color_d     = color_q;
        // A new request in the flip cycle stays pending for the next frame.
        pend_d      = swap_req || (pend_q && !flip);
        rd_off_d    = rd_off_q ^ flip;
        swap_done_d = flip;

        if ((state_q == IDLE) && accept) begin
            col_start_d = bus.cmd_x;
            col_d       = bus.cmd_x;
            row_d       = bus.cmd_y;
            col_end_d   = (x_plus_w > H_END) ? H_END : x_plus_w;
            row_end_d   = (y_plus_h > V_END) ? V_END : y_plus_h;
            // Constant-coefficient product seeds the base once; rows then step by addition.
            row_base_d  = 19'(bus.cmd_y) * H_STEP;
            color_d     = bus.cmd_color;
        end else if (state_q == FILL) begin
            if (last_col) begin
                col_d      = col_start_q;
                row_d      = row_q + 10'd1;
                row_base_d = row_base_q + H_STEP;
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    always_comb begin
        // swap_req gates ready so a simultaneous command waits behind the flip.
        bus.cmd_ready    = rst_n && (state_q == IDLE) && !pend_q && !swap_req;
        busy             = (state_q != IDLE);
        bus.sram_wr_en   = (state_q == FILL);
        bus.sram_wr_addr = row_base_q + 19'(col_q);
        bus.sram_wr_data = color_q;
    end

    assign rd_addr_offset = rd_off_q;
    assign wr_addr_offset = ~rd_off_q;
    assign swap_done      = swap_done_q;
endmodule

// File: tb/tb_frame_filler.sv
// Self-checking bench for frame_filler: vector table, randomized fills against a
// pixel-list reference model, and hand-written swap/reset sequences.
module tb_frame_filler;
    localparam int H = 800;
    localparam int V = 600;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic swap_req = 1'b0;
    logic vga_vsync = 1'b0;
    logic wr_addr_offset, rd_addr_offset, busy, swap_done;

    int checks = 0;
    int errors = 0;

    frame_filler_if bus();

    frame_filler #(.H_RES(H), .V_RES(V)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .swap_req       (swap_req),
        .vga_vsync      (vga_vsync),
        .wr_addr_offset (wr_addr_offset),
        .rd_addr_offset (rd_addr_offset),
        .busy           (busy),
        .swap_done      (swap_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          x, y, w, h;
        logic [31:0] color;
        int          n, first, last;
    } vec_t;

    vec_t vecs[10];
    int unsigned exp_q[$];
    int obs_n, obs_first, obs_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference: list every clipped pixel in row-major order.
    function automatic void build_exp(input int x, input int y, input int w, input int h);
        exp_q.delete();
        for (int r = y; (r < y + h) && (r < V); r++)
            for (int c = x; (c < x + w) && (c < H); c++)
                exp_q.push_back(r * H + c);
    endfunction

    task automatic wait_ready();
        int waited;
        waited = 0;
        while (!bus.cmd_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic drive_cmd(input int x, input int y, input int w, input int h,
                             input logic [31:0] color);
        bus.cmd_valid = 1'b1;
        bus.cmd_x     = x[9:0];
        bus.cmd_y     = y[9:0];
        bus.cmd_w     = w[9:0];
        bus.cmd_h     = h[9:0];
        bus.cmd_color = color;
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [31:0] color);
        int n;
        build_exp(x, y, w, h);
        n = exp_q.size();
        @(negedge clk);
        wait_ready();
        drive_cmd(x, y, w, h, color);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        obs_n = 0;
        obs_first = -1;
        obs_last = -1;
        for (int k = 0; k <= n; k++) begin
            chk("wr_en", 32'(bus.sram_wr_en), 32'(k < n));
            if (bus.sram_wr_en) begin
                if (obs_n == 0) obs_first = int'(bus.sram_wr_addr);
                obs_last = int'(bus.sram_wr_addr);
                obs_n++;
                if (k < n) begin
                    chk("wr_addr", 32'(bus.sram_wr_addr), exp_q[k]);
                    chk("wr_data", bus.sram_wr_data, color);
                end
            end
            if (k < n) @(negedge clk);
        end
        chk("busy_after_fill", 32'(busy), 32'd0);
        chk("ready_after_fill", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int x, y, w, h;

        vecs[0] = '{10, 2, 3, 2, 32'hFF00FF00, 6, 1610, 2412};
        vecs[1] = '{798, 599, 5, 4, 32'h12345678, 2, 479998, 479999};
        vecs[2] = '{0, 0, 0, 5, 32'h1, 0, -1, -1};
        vecs[3] = '{800, 0, 5, 5, 32'h2, 0, -1, -1};
        vecs[4] = '{0, 600, 1, 1, 32'h3, 0, -1, -1};
        vecs[5] = '{5, 5, 5, 0, 32'h4, 0, -1, -1};
        vecs[6] = '{0, 0, 1, 1, 32'hDEADBEEF, 1, 0, 0};
        vecs[7] = '{795, 10, 10, 1, 32'hA5A5A5A5, 5, 8795, 8799};
        vecs[8] = '{1023, 1023, 1023, 1023, 32'h5, 0, -1, -1};
        vecs[9] = '{799, 0, 1023, 2, 32'hCAFEF00D, 2, 799, 1599};

        bus.cmd_valid = 1'b0;
        bus.cmd_x = '0;
        bus.cmd_y = '0;
        bus.cmd_w = '0;
        bus.cmd_h = '0;
        bus.cmd_color = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(bus.sram_wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_swap_done", 32'(swap_done), 32'd0);
        chk("rst_rd_off", 32'(rd_addr_offset), 32'd0);
        chk("rst_wr_off", 32'(wr_addr_offset), 32'd1);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        chk("ready_after_reset_edge", 32'(bus.cmd_ready), 32'd1);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].color);
            chk("tbl_count", 32'(obs_n), 32'(vecs[i].n));
            chk("tbl_first", 32'(obs_first), 32'(vecs[i].first));
            chk("tbl_last", 32'(obs_last), 32'(vecs[i].last));
        end

        // Randomized fills, biased toward the right/bottom edges
        for (int i = 0; i < 12; i++) begin
            x = $urandom_range(0, 1) ? 780 + $urandom_range(0, 25) : $urandom_range(0, 779);
            y = $urandom_range(0, 1) ? 595 + $urandom_range(0, 7) : $urandom_range(0, 594);
            w = $urandom_range(0, 30);
            h = $urandom_range(0, 4);
            run_cmd(x, y, w, h, $urandom);
            chk("rnd_count", 32'(obs_n), 32'(exp_q.size()));
        end

        // swap_req during a 100-pixel fill, vsync edge during the fill is ignored
        build_exp(50, 3, 100, 1);
        @(negedge clk);
        wait_ready();
        drive_cmd(50, 3, 100, 1, 32'h0BADCAFE);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 112; k++) begin
            chk("swp_wr_en", 32'(bus.sram_wr_en), 32'(k < 100));
            if (k < 100 && bus.sram_wr_en) chk("swp_wr_addr", 32'(bus.sram_wr_addr), exp_q[k]);
            chk("swp_no_early_flip", 32'(rd_addr_offset), 32'd0);
            chk("swp_no_early_done", 32'(swap_done), 32'd0);
            if (k >= 100) chk("swp_ready_blocked", 32'(bus.cmd_ready), 32'd0);
            if (k >= 102) chk("swp_busy_wait", 32'(busy), 32'd1);
            if (k == 5)  swap_req = 1'b1;
            if (k == 6)  swap_req = 1'b0;
            if (k == 40) swap_req = 1'b1;
            if (k == 41) swap_req = 1'b0;
            if (k == 20) vga_vsync = 1'b1;
            if (k == 30) vga_vsync = 1'b0;
            @(negedge clk);
        end
        vga_vsync = 1'b1;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (swap_done) break;
        end
        chk("swp_latency_2_3", 32'((n >= 2) && (n <= 3)), 32'd1);
        chk("swp_rd_off", 32'(rd_addr_offset), 32'd1);
        chk("swp_wr_off", 32'(wr_addr_offset), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("swp_single_pulse", 32'(swap_done), 32'd0);
            chk("swp_idle_after", 32'(busy), 32'd0);
        end
        chk("swp_ready_after", 32'(bus.cmd_ready), 32'd1);
        vga_vsync = 1'b0;
        repeat (4) @(negedge clk);

        // Reset on the third write aborts the fill and restores the offsets
        @(negedge clk);
        wait_ready();
        drive_cmd(0, 0, 10, 2, 32'h77777777);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rstf_wr_en", 32'(bus.sram_wr_en), 32'd1);
            chk("rstf_wr_addr", 32'(bus.sram_wr_addr), 32'(k));
            if (k == 0) swap_req = 1'b1;
            if (k == 1) swap_req = 1'b0;
            if (k == 2) rst_n = 1'b0;
            if (k < 2) @(negedge clk);
        end
        @(negedge clk);
        chk("rstf_wr_en_off", 32'(bus.sram_wr_en), 32'd0);
        chk("rstf_busy", 32'(busy), 32'd0);
        chk("rstf_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rstf_rd_off", 32'(rd_addr_offset), 32'd0);
        chk("rstf_wr_off", 32'(wr_addr_offset), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rstf_no_writes", 32'(bus.sram_wr_en), 32'd0);
            chk("rstf_pending_cleared", 32'(busy), 32'd0);
        end
        chk("rstf_ready_after", 32'(bus.cmd_ready), 32'd1);

        // swap_req and cmd_valid in the same IDLE cycle: swap first
        swap_req = 1'b1;
        drive_cmd(0, 0, 2, 1, 32'h13572468);
        #1;
        chk("both_ready_low", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        swap_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("both_busy", 32'(busy), 32'd1);
            chk("both_no_write", 32'(bus.sram_wr_en), 32'd0);
            chk("both_ready_blocked", 32'(bus.cmd_ready), 32'd0);
            @(negedge clk);
        end
        vga_vsync = 1'b1;
        n = 0;
        while (n < 10 && !swap_done) begin
            @(negedge clk);
            n++;
            if (!swap_done) chk("both_no_write_wait", 32'(bus.sram_wr_en), 32'd0);
        end
        chk("both_swap_done", 32'(swap_done), 32'd1);
        chk("both_rd_off", 32'(rd_addr_offset), 32'd1);
        chk("both_wr_off", 32'(wr_addr_offset), 32'd0);
        chk("both_wr_en_at_flip", 32'(bus.sram_wr_en), 32'd0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("both_w0_en", 32'(bus.sram_wr_en), 32'd1);
        chk("both_w0_addr", 32'(bus.sram_wr_addr), 32'd0);
        chk("both_w0_data", bus.sram_wr_data, 32'h13572468);
        @(negedge clk);
        chk("both_w1_en", 32'(bus.sram_wr_en), 32'd1);
        chk("both_w1_addr", 32'(bus.sram_wr_addr), 32'd1);
        @(negedge clk);
        chk("both_done_en", 32'(bus.sram_wr_en), 32'd0);
        chk("both_done_busy", 32'(busy), 32'd0);
        vga_vsync = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_filler.md
FRAME_FILLER -- requirements
Module: frame_filler

Interface
REQ-001 Parameter H_RES, default 800: visible pixels per line, one 32-bit SRAM word per pixel.
REQ-002 Parameter V_RES, default 600: visible lines per frame.
REQ-003 clk  input  1  single clock for all logic (100 MHz SRAM-controller domain).
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_valid  input  1  fill command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-007 cmd_x, cmd_y  input  10 each  top-left pixel of rectangle.
REQ-008 cmd_w, cmd_h  input  10 each  rectangle width/height in pixels.
REQ-009 cmd_color  input  32  pixel word written.
REQ-010 swap_req  input  1  one-cycle pulse requesting a front/back buffer flip.
REQ-011 vga_vsync  input  1  vsync from the VGA timing generator, active-high, asynchronous to clk.
REQ-012 sram_wr_en  output  1  write strobe to SRAM controller, one word per cycle.
REQ-013 sram_wr_addr  output  19  pixel address within the back page.
REQ-014 sram_wr_data  output  32  pixel word.
REQ-015 wr_addr_offset  output  1  back (write) page select; always the inverse of rd_addr_offset.
REQ-016 rd_addr_offset  output  1  front (display) page select.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 swap_done  output  1  one-cycle pulse on the cycle the page flip takes effect.

Function
REQ-019 States SHALL be IDLE, FILL, SWAP_WAIT.
REQ-020 cmd_ready SHALL be 1 only in IDLE with no pending swap.
REQ-021 On accept, the block SHALL latch the command and clip it: col_end = min(x+w, H_RES), row_end = min(y+h, V_RES), computed at 11 bits without overflow.
REQ-022 Degenerate commands (w==0, h==0, x>=H_RES, or y>=V_RES) SHALL produce zero writes; the block stays in IDLE and cmd_ready remains 1 on the next cycle.
REQ-023 Valid commands SHALL enter FILL the cycle after accept; the first write SHALL occur in that first FILL cycle.
REQ-024 FILL SHALL issue exactly one write per cycle in row-major order, sram_wr_addr = row*H_RES + col, sram_wr_data = latched color, without gaps.
REQ-025 The multiply SHALL be replaced by a row-base register incremented by H_RES at each row wrap.
REQ-026 After the last pixel (col_end-1, row_end-1), the block SHALL return to IDLE on the next cycle; total writes = (col_end-x)*(row_end-y).
REQ-027 swap_req SHALL set a sticky pending flag in any state; repeated pulses before the flip SHALL merge into one flip.
REQ-028 In IDLE with swap pending, the block SHALL enter SWAP_WAIT; a pending swap SHALL take priority over a simultaneous cmd_valid.
REQ-029 vga_vsync SHALL pass through a two-flop synchronizer; the rising edge SHALL be detected on the synchronized signal.
REQ-030 In SWAP_WAIT, on the first detected rising edge, the block SHALL toggle rd_addr_offset, pulse swap_done for one cycle, clear pending, and return to IDLE the same cycle.
REQ-031 A vsync edge while not in SWAP_WAIT SHALL be ignored; a swap_req arriving during FILL SHALL be honoured only after FILL completes.
REQ-032 sram_wr_en SHALL be 0 in IDLE and SWAP_WAIT; sram_wr_addr and sram_wr_data are don't-care when sram_wr_en is 0.

Reset
REQ-033 While rst_n==0 at a clk edge: state=IDLE, rd_addr_offset=0, wr_addr_offset=1, sram_wr_en=0, swap_done=0, busy=0, cmd_ready=0, swap pending cleared, synchronizer flops=0.
REQ-034 cmd_ready SHALL be 1 on the first cycle after rst_n returns high.
REQ-035 Reset during FILL or SWAP_WAIT SHALL abort immediately with no further writes and no flip.

Verification
REQ-036 Cmd x=10, y=2, w=3, h=2, color=0xFF00FF00: exactly 6 writes on consecutive cycles, addresses 1610, 1611, 1612, 2410, 2411, 2412, then busy=0.
REQ-037 Cmd x=798, y=599, w=5, h=4: exactly 2 writes, addresses 479998 and 479999.
REQ-038 Cmd with w=0, and separately with x=800: zero writes, cmd_ready stays 1.
REQ-039 swap_req during a 100-pixel fill, then vsync rising edge: the flip occurs only after the last write, 2-3 cycles after the edge; rd_addr_offset goes 0->1, wr_addr_offset goes 1->0, swap_done pulses once.
REQ-040 swap_req and cmd_valid asserted in the same IDLE cycle: cmd is not accepted until after swap_done.
REQ-041 rst_n asserted on the 3rd write of a fill: sram_wr_en is 0 from the next cycle, offsets return to rd=0/wr=1.
